// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet controller and its read engine.
// Holds the read-engine state enum, the controller state enum and the length helpers.
// No logic of its own; imported by pkt_rd_engine and the controller.
package pkt_pkg;

    // Read-engine states; the encoding is exported on state_out for debug.
    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_HUNT    = 3'd1,
        RD_CAPTURE = 3'd2,
        RD_DRAIN   = 3'd3,
        RD_DONE    = 3'd4
    } rd_state_t;

    // Packet controller states (the request side of the rd_ctrl handshake).
    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'd0,
        CTRL_REQ     = 2'd1,
        CTRL_BUSY    = 2'd2,
        CTRL_RELEASE = 2'd3
    } ctrl_state_t;

    // Default stream width and its byte count.
    localparam int PKT_DATA_W     = 32;
    localparam int BYTES_PER_WORD = PKT_DATA_W / 8;

    // Reported packet length width and its saturation value.
    localparam int              PKT_LEN_W   = 16;
    localparam logic [15:0]     PKT_LEN_SAT = 16'hFFFF;

    // Bytes per stream word for an arbitrary (multiple-of-8) width.
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Clamp a wide byte count into the 16-bit length field.
    function automatic logic [15:0] sat_len(input logic [31:0] len);
        if (len > {16'h0000, PKT_LEN_SAT}) begin
            return PKT_LEN_SAT;
        end
        return len[15:0];
    endfunction

endpackage

// File: rtl/pkt_rd_engine.sv
// Captures one packet per rd_ctrl request from the ingress stream into the capture buffer.
// Latency: buffer write and rd_ctrl_rdy appear 1 cycle after the beat is accepted.
// Backpressure: st_ready high only in HUNT/CAPTURE/DRAIN; one beat per cycle, no bubbles.
//
// Ports:
//   clk, reset (sync, active-low)
//   rd_ctrl / rd_ctrl_rdy              : level request / completion handshake with the controller
//   st_data/st_valid/st_sop/st_eop/st_empty/st_ready : MAC-side stream, byte 0 in the MSBs
//   buf_wr_en/buf_wr_addr/buf_wr_data  : registered capture-buffer write port
//   pkt_len, pkt_truncated             : result of the capture, valid while rd_ctrl_rdy is high
//   state_out                          : current FSM state for debug
module pkt_rd_engine
    import pkt_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_ctrl,
    output logic                          rd_ctrl_rdy,
    input  logic [DATA_W-1:0]             st_data,
    input  logic                          st_valid,
    input  logic                          st_sop,
    input  logic                          st_eop,
    input  logic [$clog2(DATA_W/8)-1:0]   st_empty,
    output logic                          st_ready,
    output logic                          buf_wr_en,
    output logic [ADDR_W-1:0]             buf_wr_addr,
    output logic [DATA_W-1:0]             buf_wr_data,
    output logic [15:0]                   pkt_len,
    output logic                          pkt_truncated,
    output logic [2:0]                    state_out
);

    localparam int BPW    = bytes_per_word(DATA_W);
    // One extra bit so the counter can hold MAX_WORDS == 2**ADDR_W.
    localparam int WCNT_W = ADDR_W + 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WORDS);

    rd_state_t          state;
    logic [WCNT_W-1:0]  wcnt;
    logic               accept;
    logic [31:0]        len_single;
    logic [31:0]        len_eop;
    logic [31:0]        len_trunc;

    assign st_ready  = (state == RD_HUNT) || (state == RD_CAPTURE) || (state == RD_DRAIN);
    assign accept    = st_valid && st_ready;
    assign state_out = state;

    // Length arithmetic is done wide so that no legal parameter set wraps
    // before the result is clamped to 16 bits.
    assign len_single = 32'(BPW) - 32'(st_empty);
    assign len_eop    = (32'(wcnt) + 32'd1) * 32'(BPW) - 32'(st_empty);
    assign len_trunc  = 32'(MAX_WORDS) * 32'(BPW);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= RD_IDLE;
            wcnt          <= '0;
            rd_ctrl_rdy   <= 1'b0;
            buf_wr_en     <= 1'b0;
            buf_wr_addr   <= '0;
            buf_wr_data   <= '0;
            pkt_len       <= '0;
            pkt_truncated <= 1'b0;
        end else begin
            buf_wr_en <= 1'b0;
            case (state)
                RD_IDLE: begin
                    wcnt <= '0;
                    if (rd_ctrl) begin
                        state         <= RD_HUNT;
                        pkt_len       <= '0;
                        pkt_truncated <= 1'b0;
                    end
                end

                RD_HUNT, RD_CAPTURE, RD_DRAIN: begin
                    if (!rd_ctrl) begin
                        // Abort: a beat presented in this cycle is dropped, not written.
                        state         <= RD_IDLE;
                        pkt_len       <= '0;
                        pkt_truncated <= 1'b0;
                    end else if (accept) begin
                        if (st_sop && (state != RD_DRAIN)) begin
                            // First sop in HUNT, or a restart mid-CAPTURE: begin at word 0.
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= '0;
                            buf_wr_data <= st_data;
                            wcnt        <= WCNT_W'(1);
                            if (st_eop) begin
                                state       <= RD_DONE;
                                rd_ctrl_rdy <= 1'b1;
                                pkt_len     <= sat_len(len_single);
                            end else begin
                                state <= RD_CAPTURE;
                            end
                        end else if (state == RD_CAPTURE) begin
                            if (st_eop) begin
                                buf_wr_en   <= 1'b1;
                                buf_wr_addr <= wcnt[ADDR_W-1:0];
                                buf_wr_data <= st_data;
                                wcnt        <= wcnt + 1'b1;
                                state       <= RD_DONE;
                                rd_ctrl_rdy <= 1'b1;
                                pkt_len     <= sat_len(len_eop);
                            end else if (wcnt == WCNT_MAX) begin
                                // Buffer full and more data coming: stop storing, drain to eop.
                                pkt_truncated <= 1'b1;
                                pkt_len       <= sat_len(len_trunc);
                                state         <= RD_DRAIN;
                            end else begin
                                buf_wr_en   <= 1'b1;
                                buf_wr_addr <= wcnt[ADDR_W-1:0];
                                buf_wr_data <= st_data;
                                wcnt        <= wcnt + 1'b1;
                            end
                        end else if ((state == RD_DRAIN) && st_eop) begin
                            state       <= RD_DONE;
                            rd_ctrl_rdy <= 1'b1;
                        end
                    end
                end

                RD_DONE: begin
                    if (!rd_ctrl) begin
                        state       <= RD_IDLE;
                        rd_ctrl_rdy <= 1'b0;
                    end
                end

                default: begin
                    state       <= RD_IDLE;
                    rd_ctrl_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule
